// File: rtl/fm_dac_multi.sv
// rtl/fm_dac_multi.sv - multi-channel FM sine PWM DAC driven by per-channel distance words
// Optional macro FM_DAC_RAMP_EN: slew each channel's phase increment toward its target.
module fm_dac_multi #(
    parameter int CHANNELS       = 2,
    parameter int DIST_WIDTH     = 13,
    parameter int SINE_WIDTH     = 8,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int MAX_DIST       = 2000,
    parameter int BASE_INC       = 1024,
    parameter int INC_SCALE      = 256,
    parameter int RAMP_STEP      = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [CHANNELS*DIST_WIDTH-1:0] distance,
    input  logic [CHANNELS-1:0]            dist_valid,
    output logic [CHANNELS-1:0]            dist_ready,
    output logic [CHANNELS-1:0]            pwm_out,
    output logic [CHANNELS*SINE_WIDTH-1:0] sample_out,
    output logic                           period_tick
);
    localparam int LUT_SIZE = 1 << LUT_ADDR_WIDTH;

    function automatic logic [SINE_WIDTH-1:0] sine_entry(input int idx);
        real amp;
        real s;
        amp = ((2.0 ** SINE_WIDTH) - 1.0) / 2.0;
        s   = amp * (1.0 + $sin(2.0 * 3.14159265358979 * idx / LUT_SIZE));
        return SINE_WIDTH'($rtoi(s + 0.5));
    endfunction

    function automatic logic [PHASE_WIDTH-1:0] inc_for(input logic [DIST_WIDTH-1:0] d);
        logic [63:0] dz;
        logic [63:0] cl;
        dz = 64'(d);
        cl = (dz > 64'(MAX_DIST)) ? 64'(MAX_DIST) : dz;
        return PHASE_WIDTH'(64'(BASE_INC) + cl * 64'(INC_SCALE));
    endfunction

`ifdef FM_DAC_RAMP_EN
    function automatic logic [PHASE_WIDTH-1:0] ramp_toward(input logic [PHASE_WIDTH-1:0] cur,
                                                         input logic [PHASE_WIDTH-1:0] tgt);
        logic [PHASE_WIDTH-1:0] step;
        step = PHASE_WIDTH'(RAMP_STEP);
        if (tgt > cur)
            return ((tgt - cur) > step) ? cur + step : tgt;
        else
            return ((cur - tgt) > step) ? cur - step : tgt;
    endfunction
`endif

    logic [SINE_WIDTH-1:0] lut [LUT_SIZE];
    for (genvar i = 0; i < LUT_SIZE; i++) begin : g_lut
        assign lut[i] = sine_entry(i);
    end

    logic [SINE_WIDTH-1:0]  counter_q, counter_d;
    logic [PHASE_WIDTH-1:0] phase_q  [CHANNELS];
    logic [PHASE_WIDTH-1:0] phase_d  [CHANNELS];
    logic [PHASE_WIDTH-1:0] inc_q    [CHANNELS];
    logic [PHASE_WIDTH-1:0] inc_d    [CHANNELS];
    logic [PHASE_WIDTH-1:0] target_q [CHANNELS];
    logic [PHASE_WIDTH-1:0] target_d [CHANNELS];
    logic [SINE_WIDTH-1:0]  duty_q   [CHANNELS];
    logic [SINE_WIDTH-1:0]  duty_d   [CHANNELS];
    logic [DIST_WIDTH-1:0]  pend_q   [CHANNELS];
    logic [DIST_WIDTH-1:0]  pend_d   [CHANNELS];
    logic [CHANNELS-1:0]    pend_v_q, pend_v_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic                   boundary;

    assign boundary    = enable && (counter_q == '0);
    assign period_tick = boundary && !reset;
    assign dist_ready  = ~pend_v_q;
    assign pwm_out     = pwm_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign sample_out[c*SINE_WIDTH +: SINE_WIDTH] = duty_q[c];
    end

    always_comb begin
        counter_d = enable ? counter_q + SINE_WIDTH'(1) : counter_q;
        pend_v_d  = pend_v_q;
        pwm_d     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            phase_d[c]  = phase_q[c];
            inc_d[c]    = inc_q[c];
            target_d[c] = target_q[c];
            duty_d[c]   = duty_q[c];
            pend_d[c]   = pend_q[c];
            if (boundary) begin
                duty_d[c]  = lut[phase_q[c][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]];
                phase_d[c] = phase_q[c] + inc_q[c];
                if (pend_v_q[c]) begin
                    target_d[c] = inc_for(pend_q[c]);
                    pend_v_d[c] = 1'b0;
                end
`ifdef FM_DAC_RAMP_EN
                // A freshly loaded target holds inc for this boundary; stepping starts next one.
                if (!pend_v_q[c])
                    inc_d[c] = ramp_toward(inc_q[c], target_q[c]);
`else
                inc_d[c] = target_d[c];
`endif
            end
            // Ready is low while a value is pending, so a boundary-coincident capture lands next period.
            if (dist_valid[c] && !pend_v_q[c]) begin
                pend_d[c]   = distance[c*DIST_WIDTH +: DIST_WIDTH];
                pend_v_d[c] = 1'b1;
            end
            // Compare against the duty in force for this period, including the one just loaded.
            pwm_d[c] = enable && (counter_q < duty_d[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            pend_v_q  <= '0;
            pwm_q     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c]  <= '0;
                inc_q[c]    <= PHASE_WIDTH'(BASE_INC);
                target_q[c] <= PHASE_WIDTH'(BASE_INC);
                duty_q[c]   <= '0;
                pend_q[c]   <= '0;
            end
        end else begin
            counter_q <= counter_d;
            pend_v_q  <= pend_v_d;
            pwm_q     <= pwm_d;
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c]  <= phase_d[c];
                inc_q[c]    <= inc_d[c];
                target_q[c] <= target_d[c];
                duty_q[c]   <= duty_d[c];
                pend_q[c]   <= pend_d[c];
            end
        end
    end
endmodule
